// File: rtl/relu_layer.sv
// relu_layer: eight-channel ReLU stage between the convolution layer and pooling.
// Each channel is a RELU_X x RELU_Y map of signed two's-complement words.
// While relu_enable is high, every element of all eight maps is rectified
// (negative -> 0, non-negative -> unchanged) and registered on the rising edge.
// relu_done marks that the outputs hold the result of an enabled sample.
//
// Ports
//   clk                           clock, all state on rising edge
//   rst                           synchronous active-high reset (priority over enable)
//   relu_enable                   level-sensitive sample-and-rectify request
//   conv_result_1..conv_result_8  input maps [RELU_DATA_WIDTH-1:0] [RELU_X-1:0][RELU_Y-1:0]
//   relu_result_1..relu_result_8  registered rectified maps, same shape
//   relu_done                     high one edge after an enabled sample, low otherwise
module relu_layer #(
  parameter int RELU_DATA_WIDTH = 45,
  parameter int RELU_X          = 24,
  parameter int RELU_Y          = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       relu_enable,
  input  logic [RELU_DATA_WIDTH-1:0] conv_result_1 [RELU_X-1:0][RELU_Y-1:0],
  input  logic [RELU_DATA_WIDTH-1:0] conv_result_2 [RELU_X-1:0][RELU_Y-1:0],
  input  logic [RELU_DATA_WIDTH-1:0] conv_result_3 [RELU_X-1:0][RELU_Y-1:0],
  input  logic [RELU_DATA_WIDTH-1:0] conv_result_4 [RELU_X-1:0][RELU_Y-1:0],
  input  logic [RELU_DATA_WIDTH-1:0] conv_result_5 [RELU_X-1:0][RELU_Y-1:0],
  input  logic [RELU_DATA_WIDTH-1:0] conv_result_6 [RELU_X-1:0][RELU_Y-1:0],
  input  logic [RELU_DATA_WIDTH-1:0] conv_result_7 [RELU_X-1:0][RELU_Y-1:0],
  input  logic [RELU_DATA_WIDTH-1:0] conv_result_8 [RELU_X-1:0][RELU_Y-1:0],
  output logic [RELU_DATA_WIDTH-1:0] relu_result_1 [RELU_X-1:0][RELU_Y-1:0],
  output logic [RELU_DATA_WIDTH-1:0] relu_result_2 [RELU_X-1:0][RELU_Y-1:0],
  output logic [RELU_DATA_WIDTH-1:0] relu_result_3 [RELU_X-1:0][RELU_Y-1:0],
  output logic [RELU_DATA_WIDTH-1:0] relu_result_4 [RELU_X-1:0][RELU_Y-1:0],
  output logic [RELU_DATA_WIDTH-1:0] relu_result_5 [RELU_X-1:0][RELU_Y-1:0],
  output logic [RELU_DATA_WIDTH-1:0] relu_result_6 [RELU_X-1:0][RELU_Y-1:0],
  output logic [RELU_DATA_WIDTH-1:0] relu_result_7 [RELU_X-1:0][RELU_Y-1:0],
  output logic [RELU_DATA_WIDTH-1:0] relu_result_8 [RELU_X-1:0][RELU_Y-1:0],
  output logic                       relu_done
);

  localparam int NCH = 8;

  // Channels gathered into one array so the generate loops can index them.
  // Row/column ranges match the ports so whole-map assignments map element for element.
  logic [RELU_DATA_WIDTH-1:0] conv_all [0:NCH-1][RELU_X-1:0][RELU_Y-1:0];
  logic [RELU_DATA_WIDTH-1:0] res_q    [0:NCH-1][RELU_X-1:0][RELU_Y-1:0];

  assign conv_all[0] = conv_result_1;
  assign conv_all[1] = conv_result_2;
  assign conv_all[2] = conv_result_3;
  assign conv_all[3] = conv_result_4;
  assign conv_all[4] = conv_result_5;
  assign conv_all[5] = conv_result_6;
  assign conv_all[6] = conv_result_7;
  assign conv_all[7] = conv_result_8;

  assign relu_result_1 = res_q[0];
  assign relu_result_2 = res_q[1];
  assign relu_result_3 = res_q[2];
  assign relu_result_4 = res_q[3];
  assign relu_result_5 = res_q[4];
  assign relu_result_6 = res_q[5];
  assign relu_result_7 = res_q[6];
  assign relu_result_8 = res_q[7];

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    for (genvar i = 0; i < RELU_X; i++) begin : g_row
      for (genvar j = 0; j < RELU_Y; j++) begin : g_col
        always_ff @(posedge clk) begin
          if (rst) begin
            res_q[c][i][j] <= '0;
          end else if (relu_enable) begin
            // Sign bit alone decides: negative clears, everything else passes bit-exact.
            res_q[c][i][j] <= conv_all[c][i][j][RELU_DATA_WIDTH-1] ? '0 : conv_all[c][i][j];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      relu_done <= 1'b0;
    end else begin
      relu_done <= relu_enable;
    end
  end

endmodule

// File: tb/tb_relu_layer.sv
module tb_relu_layer;

  localparam int W   = 45;
  localparam int X   = 24;
  localparam int Y   = 24;
  localparam int NCH = 8;

  logic clk = 1'b0;
  logic rst;
  logic en;

  logic [W-1:0] c1 [X-1:0][Y-1:0];
  logic [W-1:0] c2 [X-1:0][Y-1:0];
  logic [W-1:0] c3 [X-1:0][Y-1:0];
  logic [W-1:0] c4 [X-1:0][Y-1:0];
  logic [W-1:0] c5 [X-1:0][Y-1:0];
  logic [W-1:0] c6 [X-1:0][Y-1:0];
  logic [W-1:0] c7 [X-1:0][Y-1:0];
  logic [W-1:0] c8 [X-1:0][Y-1:0];
  logic [W-1:0] r1 [X-1:0][Y-1:0];
  logic [W-1:0] r2 [X-1:0][Y-1:0];
  logic [W-1:0] r3 [X-1:0][Y-1:0];
  logic [W-1:0] r4 [X-1:0][Y-1:0];
  logic [W-1:0] r5 [X-1:0][Y-1:0];
  logic [W-1:0] r6 [X-1:0][Y-1:0];
  logic [W-1:0] r7 [X-1:0][Y-1:0];
  logic [W-1:0] r8 [X-1:0][Y-1:0];
  logic done;

  relu_layer #(.RELU_DATA_WIDTH(W), .RELU_X(X), .RELU_Y(Y)) dut (
    .clk(clk), .rst(rst), .relu_enable(en),
    .conv_result_1(c1), .conv_result_2(c2), .conv_result_3(c3), .conv_result_4(c4),
    .conv_result_5(c5), .conv_result_6(c6), .conv_result_7(c7), .conv_result_8(c8),
    .relu_result_1(r1), .relu_result_2(r2), .relu_result_3(r3), .relu_result_4(r4),
    .relu_result_5(r5), .relu_result_6(r6), .relu_result_7(r7), .relu_result_8(r8),
    .relu_done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 1'b0;

  // Reference model state: what every output must hold after the latest edge.
  logic [W-1:0] exp_map [NCH][X][Y];
  logic         exp_done;

  function automatic logic [W-1:0] relu_ref(input logic [W-1:0] v);
    if ($signed(v) < 0) return '0;
    return v;
  endfunction

  function automatic logic [W-1:0] get_in(input int ch, input int i, input int j);
    case (ch)
      0: return c1[i][j];
      1: return c2[i][j];
      2: return c3[i][j];
      3: return c4[i][j];
      4: return c5[i][j];
      5: return c6[i][j];
      6: return c7[i][j];
      default: return c8[i][j];
    endcase
  endfunction

  function automatic logic [W-1:0] get_out(input int ch, input int i, input int j);
    case (ch)
      0: return r1[i][j];
      1: return r2[i][j];
      2: return r3[i][j];
      3: return r4[i][j];
      4: return r5[i][j];
      5: return r6[i][j];
      6: return r7[i][j];
      default: return r8[i][j];
    endcase
  endfunction

  task automatic set_in(input int ch, input int i, input int j, input logic [W-1:0] v);
    case (ch)
      0: c1[i][j] = v;
      1: c2[i][j] = v;
      2: c3[i][j] = v;
      3: c4[i][j] = v;
      4: c5[i][j] = v;
      5: c6[i][j] = v;
      6: c7[i][j] = v;
      default: c8[i][j] = v;
    endcase
  endtask

  function automatic logic [W-1:0] rnd45();
    logic [63:0] r;
    r = {$urandom, $urandom};
    // Bias some elements to the interesting boundaries.
    case ($urandom_range(0, 9))
      0: return '0;
      1: return {1'b0, {(W-1){1'b1}}};
      2: return {1'b1, {(W-1){1'b0}}};
      3: return '1;
      default: return r[W-1:0];
    endcase
  endfunction

  // Model update: whole-map rule applied at each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++)
        for (int i = 0; i < X; i++)
          for (int j = 0; j < Y; j++)
            exp_map[c][i][j] = '0;
      exp_done = 1'b0;
    end else if (en) begin
      for (int c = 0; c < NCH; c++)
        for (int i = 0; i < X; i++)
          for (int j = 0; j < Y; j++)
            exp_map[c][i][j] = relu_ref(get_in(c, i, j));
      exp_done = 1'b1;
    end else begin
      exp_done = 1'b0;
    end
  end

  // Compare process: one comparison per channel map and one for done, every cycle.
  always @(negedge clk) begin
    if (checking) begin
      for (int c = 0; c < NCH; c++) begin
        int bi;
        int bj;
        bi = -1;
        bj = -1;
        for (int i = 0; i < X; i++)
          for (int j = 0; j < Y; j++)
            if (bi < 0 && get_out(c, i, j) !== exp_map[c][i][j]) begin
              bi = i;
              bj = j;
            end
        n_cmp++;
        if (bi >= 0) begin
          n_bad++;
          $display("FAIL map ch%0d [%0d][%0d] at %0t: got %h expected %h",
                   c + 1, bi, bj, $time, get_out(c, bi, bj), exp_map[c][bi][bj]);
        end
      end
      n_cmp++;
      if (done !== exp_done) begin
        n_bad++;
        $display("FAIL done at %0t: got %b expected %b", $time, done, exp_done);
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic fill_split(input int ch, input logic [W-1:0] neg, input logic [W-1:0] pos);
    for (int i = 0; i < X; i++)
      for (int j = 0; j < Y; j++)
        set_in(ch, i, j, (i < 12) ? neg : pos);
  endtask

  task automatic fill_random();
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < X; i++)
        for (int j = 0; j < Y; j++)
          set_in(c, i, j, rnd45());
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    for (int c = 0; c < NCH; c++) fill_split(c, '0, '0);

    // 1. reset for two edges
    @(posedge clk);
    @(posedge clk);
    #1;
    checking = 1'b1;
    check("reset r1[0][0]", r1[0][0], '0);
    check("reset r8[23][23]", r8[23][23], '0);
    check("reset done", {44'd0, done}, '0);

    // 2. negative upper half, positive lower half, single enable
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    for (int c = 0; c < NCH; c++) fill_split(c, 45'h1fedcba98765, 45'h0fedcba98765);
    @(posedge clk);
    #1;
    check("split r1[0][0]", r1[0][0], '0);
    check("split r1[11][23]", r1[11][23], '0);
    check("split r1[12][0]", r1[12][0], 45'h0fedcba98765);
    check("split r3[23][5]", r3[23][5], 45'h0fedcba98765);
    check("split done", {44'd0, done}, 45'd1);

    // 3. distinct value per channel (ch k: ...98767 - k)
    @(negedge clk);
    for (int c = 0; c < NCH; c++)
      fill_split(c, 45'h1fedcba98767 - 45'(c + 1), 45'h0fedcba98767 - 45'(c + 1));
    @(posedge clk);
    #1;
    check("chan r5[0][0]", r5[0][0], '0);
    check("chan r5[23][23]", r5[23][23], 45'h0fedcba98762);
    check("chan r1[12][3]", r1[12][3], 45'h0fedcba98766);
    check("chan r8[12][0]", r8[12][0], 45'h0fedcba9875f);

    // 4. boundary values
    @(negedge clk);
    set_in(0, 0, 0, 45'h000000000000);
    set_in(0, 0, 1, 45'h0fffffffffff);
    set_in(0, 0, 2, 45'h100000000000);
    set_in(0, 0, 3, 45'h1fffffffffff);
    @(posedge clk);
    #1;
    check("bound zero", r1[0][0], '0);
    check("bound maxpos", r1[0][1], 45'h0fffffffffff);
    check("bound minneg", r1[0][2], '0);
    check("bound minus1", r1[0][3], '0);

    // 5. drop enable and change inputs: outputs hold
    @(negedge clk);
    en = 1'b0;
    fill_random();
    set_in(0, 0, 1, 45'h000000000001);
    @(posedge clk);
    #1;
    check("hold r1[0][1]", r1[0][1], 45'h0fffffffffff);
    check("hold r5[23][23]", r5[23][23], 45'h0fedcba98762);
    check("hold done", {44'd0, done}, '0);

    // 6. reset while enabled with valid outputs
    @(negedge clk);
    en = 1'b1;
    for (int c = 0; c < NCH; c++) fill_split(c, 45'h0000000000aa, 45'h0000000000bb);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst r2[0][0]", r2[0][0], '0);
    check("rst r7[20][9]", r7[20][9], '0);
    check("rst done", {44'd0, done}, '0);

    // Randomized phase, checked continuously by the compare process.
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 19) == 0);
      en  = ($urandom_range(0, 3) != 0);
      fill_random();
    end
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    @(negedge clk);
    #1;
    checking = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
